// File: rtl/timer_arbiter_pkg.sv
// Shared types for the timer arbiter: FSM state encoding and an index-width helper.
package timer_arbiter_pkg;

    typedef enum logic {
        IDLE     = 1'b0,
        COUNTING = 1'b1
    } state_t;

    // Width needed to hold a requester index; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/timer_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after the pointer, wrapping.
module rr_arbiter
    import timer_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   pointer,
    output logic [NUM_REQ-1:0] winner,
    output logic [IDX_W-1:0]   winner_idx,
    output logic               valid
);

    localparam logic [IDX_W:0] NUM_REQ_W = (IDX_W+1)'(NUM_REQ);

    logic [IDX_W-1:0]   cand_idx [NUM_REQ];
    logic [NUM_REQ-1:0] hit;

    // Candidate gi is the requester gi positions after the pointer, modulo NUM_REQ.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_cand
            logic [IDX_W:0] sum;
            assign sum          = {1'b0, pointer} + (IDX_W+1)'(gi);
            assign cand_idx[gi] = (sum >= NUM_REQ_W) ? IDX_W'(sum - NUM_REQ_W) : IDX_W'(sum);
            assign hit[gi]      = req[cand_idx[gi]];
        end
    endgenerate

    always_comb begin
        valid      = 1'b0;
        winner_idx = '0;
        winner     = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (hit[k]) begin
                valid      = 1'b1;
                winner_idx = cand_idx[k];
            end
        end
        winner[winner_idx] = valid;
    end

endmodule

// File: rtl/timer_arbiter.sv
// One shared down-counting timer, lent to NUM_REQ requesters in round-robin order;
// the owner gets a one-cycle done pulse on the final counted cycle.
module timer_arbiter
    import timer_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*WIDTH-1:0] cycles,
    output logic [NUM_REQ-1:0]       gnt,
    output logic [NUM_REQ-1:0]       done,
    output logic                     busy
);

    localparam int               IDX_W    = idx_width(NUM_REQ);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

    state_t           state_reg;
    logic [WIDTH-1:0] count_reg;
    logic [IDX_W-1:0] owner_reg;
    logic [IDX_W-1:0] ptr_reg;

    logic [WIDTH-1:0]   cycles_arr [NUM_REQ];
    logic [NUM_REQ-1:0] arb_winner;
    logic [IDX_W-1:0]   arb_idx;
    logic               arb_valid;
    logic [WIDTH-1:0]   load_value;
    logic [IDX_W-1:0]   ptr_next;
    logic               owner_req;
    logic               count_last;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_cycles
            assign cycles_arr[gi] = cycles[gi*WIDTH +: WIDTH];
        end
    endgenerate

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_arbiter (
        .req        (req),
        .pointer    (ptr_reg),
        .winner     (arb_winner),
        .winner_idx (arb_idx),
        .valid      (arb_valid)
    );

    // A zero count still occupies the timer for one cycle.
    assign load_value = (cycles_arr[arb_idx] == '0) ? WIDTH'(1) : cycles_arr[arb_idx];
    assign ptr_next   = (arb_idx == LAST_IDX) ? '0 : arb_idx + IDX_W'(1);
    assign owner_req  = req[owner_reg];
    assign count_last = (count_reg == WIDTH'(1));
    assign busy       = (state_reg == COUNTING);

    // An owner that has dropped its request gets no done, even on its last cycle.
    always_comb begin
        done = '0;
        if (state_reg == COUNTING && owner_req && count_last) begin
            done[owner_reg] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            gnt       <= '0;
            count_reg <= '0;
            owner_reg <= '0;
            ptr_reg   <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (arb_valid) begin
                        state_reg <= COUNTING;
                        gnt       <= arb_winner;
                        count_reg <= load_value;
                        owner_reg <= arb_idx;
                        ptr_reg   <= ptr_next;
                    end
                end
                COUNTING: begin
                    if (!owner_req || count_last) begin
                        state_reg <= IDLE;
                        gnt       <= '0;
                    end else begin
                        count_reg <= count_reg - WIDTH'(1);
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    gnt       <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_timer_arbiter.sv
// Randomized and directed stimulus against a grant-level reference model; a negedge
// monitor matches observed grant starts/ends and done pulses against queued expectations.
module tb_timer_arbiter;

    localparam int NUM_REQ = 4;
    localparam int WIDTH   = 32;

    typedef struct {
        int idx;
        int cyc;
    } start_t;

    typedef struct {
        int idx;
        int cyc;
        bit with_done;
    } end_t;

    logic                     clk;
    logic                     rst;
    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*WIDTH-1:0] cycles;
    logic [NUM_REQ-1:0]       gnt;
    logic [NUM_REQ-1:0]       done;
    logic                     busy;

    timer_arbiter #(
        .NUM_REQ (NUM_REQ),
        .WIDTH   (WIDTH)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .cycles (cycles),
        .gnt    (gnt),
        .done   (done),
        .busy   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard queues, filled by the stimulus side, drained by the monitor.
    start_t start_q [$];
    end_t   end_q [$];

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    bit final_check = 1'b0;
    bit final_done  = 1'b0;

    // Reference model: who holds the timer, how many cycles remain, where the pointer sits.
    bit                 m_busy  = 1'b0;
    int                 m_owner = 0;
    longint             m_rem   = 0;
    int                 m_ptr   = 0;
    logic [NUM_REQ-1:0] m_done_now = '0;

    logic [NUM_REQ-1:0] req_next = '0;
    logic [WIDTH-1:0]   cyc_next [NUM_REQ];

    function automatic logic [NUM_REQ-1:0] onehot(input int i);
        logic [NUM_REQ-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    task automatic model_cycle();
        bit found;
        int win;
        found      = 1'b0;
        win        = 0;
        m_done_now = '0;
        if (m_busy) begin
            if (!req[m_owner]) begin
                end_q.push_back('{m_owner, cyc, 1'b0});
                m_busy = 1'b0;
            end else if (m_rem == 1) begin
                end_q.push_back('{m_owner, cyc, 1'b1});
                m_done_now[m_owner] = 1'b1;
                m_busy = 1'b0;
            end else begin
                m_rem = m_rem - 1;
            end
        end else begin
            for (int k = 0; k < NUM_REQ; k++) begin
                int i;
                i = (m_ptr + k) % NUM_REQ;
                if (!found && req[i]) begin
                    found = 1'b1;
                    win   = i;
                end
            end
            if (found) begin
                m_busy  = 1'b1;
                m_owner = win;
                m_rem   = (cyc_next[win] == '0) ? 64'd1 : longint'(cyc_next[win]);
                m_ptr   = (win + 1) % NUM_REQ;
                start_q.push_back('{win, cyc + 1});
            end
        end
    endtask

    // One clock cycle: apply the staged inputs just after the edge, then advance the model.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        req = req_next;
        for (int i = 0; i < NUM_REQ; i++) cycles[i*WIDTH +: WIDTH] = cyc_next[i];
        model_cycle();
    endtask

    task automatic ticks(input int n);
        for (int j = 0; j < n; j++) tick();
    endtask

    task automatic set_req(input int i, input bit r, input int c);
        req_next[i] = r;
        cyc_next[i] = WIDTH'(c);
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        req      = '0;
        req_next = '0;
        start_q.delete();
        end_q.delete();
        m_busy     = 1'b0;
        m_ptr      = 0;
        m_done_now = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Monitor
    logic [NUM_REQ-1:0] prev_gnt  = '0;
    bit                 done_seen = 1'b0;

    always @(negedge clk) begin
        start_t s;
        end_t   e;
        if (rst) begin
            n_vec++;
            if (gnt !== '0 || busy !== 1'b0 || done !== '0) begin
                n_err++;
                $display("FAIL reset_state cyc=%0d gnt=%b busy=%b done=%b want all zero", cyc, gnt, busy, done);
            end
            prev_gnt  = '0;
            done_seen = 1'b0;
        end else begin
            n_vec++;
            if (busy !== (gnt != '0)) begin
                n_err++;
                $display("FAIL busy_vs_gnt cyc=%0d busy=%b gnt=%b", cyc, busy, gnt);
            end
            if (gnt != '0 && prev_gnt == '0) begin
                n_vec++;
                done_seen = 1'b0;
                if (start_q.size() == 0) begin
                    n_err++;
                    $display("FAIL grant_start cyc=%0d gnt=%b but no grant expected", cyc, gnt);
                end else begin
                    s = start_q.pop_front();
                    if (gnt !== onehot(s.idx) || cyc != s.cyc) begin
                        n_err++;
                        $display("FAIL grant_start cyc=%0d gnt=%b want gnt=%b at cyc=%0d",
                                 cyc, gnt, onehot(s.idx), s.cyc);
                    end
                end
            end
            if (gnt != '0 && prev_gnt != '0) begin
                n_vec++;
                if (gnt !== prev_gnt) begin
                    n_err++;
                    $display("FAIL grant_stable cyc=%0d gnt=%b want %b", cyc, gnt, prev_gnt);
                end
            end
            if (done != '0) begin
                n_vec++;
                done_seen = 1'b1;
                if (done !== gnt) begin
                    n_err++;
                    $display("FAIL done_with_gnt cyc=%0d done=%b want equal to gnt=%b", cyc, done, gnt);
                end
            end
            if (gnt == '0 && prev_gnt != '0) begin
                n_vec++;
                if (end_q.size() == 0) begin
                    n_err++;
                    $display("FAIL grant_end cyc=%0d grant %b ended but no end expected", cyc, prev_gnt);
                end else begin
                    e = end_q.pop_front();
                    if (prev_gnt !== onehot(e.idx) || (cyc - 1) != e.cyc || done_seen != e.with_done) begin
                        n_err++;
                        $display("FAIL grant_end cyc=%0d last gnt=%b last cyc=%0d done=%0b want gnt=%b last cyc=%0d done=%0b",
                                 cyc, prev_gnt, cyc - 1, done_seen, onehot(e.idx), e.cyc, e.with_done);
                    end
                end
            end
            prev_gnt = gnt;
            if (final_check && !final_done) begin
                n_vec++;
                if (start_q.size() != 0 || end_q.size() != 0) begin
                    n_err++;
                    $display("FAIL drain cyc=%0d pending starts=%0d ends=%0d want 0 and 0",
                             cyc, start_q.size(), end_q.size());
                end
                final_done = 1'b1;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < NUM_REQ; i++) cyc_next[i] = '0;
        rst    = 1'b1;
        req    = '0;
        cycles = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Single request of 3 cycles.
        set_req(0, 1'b1, 3);
        ticks(4);
        set_req(0, 1'b0, 3);
        ticks(3);

        // Fairness: everyone requesting, 2 cycles each.
        for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b1, 2);
        ticks(16);
        req_next = '0;
        ticks(4);

        // Zero count behaves as one cycle.
        set_req(2, 1'b1, 0);
        ticks(2);
        set_req(2, 1'b0, 0);
        ticks(3);

        // Abort on the 4th grant cycle while requester 2 waits.
        set_req(1, 1'b1, 10);
        set_req(2, 1'b1, 2);
        ticks(4);
        set_req(1, 1'b0, 10);
        ticks(5);
        set_req(2, 1'b0, 2);
        ticks(3);

        // Count sampled only at grant.
        set_req(3, 1'b1, 5);
        ticks(3);
        cyc_next[3] = WIDTH'(1);
        ticks(4);
        set_req(3, 1'b0, 1);
        ticks(3);

        // Reset mid-count, then the pointer must restart at 0.
        set_req(1, 1'b1, 100);
        ticks(51);
        do_reset();
        set_req(1, 1'b1, 3);
        set_req(3, 1'b1, 3);
        ticks(5);
        req_next = '0;
        ticks(10);

        // Randomized traffic.
        for (int n = 0; n < 2500; n++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (m_busy && m_owner == i) begin
                    if ($urandom_range(39) == 0) req_next[i] = 1'b0;
                    if ($urandom_range(3) == 0) cyc_next[i] = WIDTH'($urandom_range(7));
                end else if (m_done_now[i]) begin
                    if ($urandom_range(3) != 0) req_next[i] = 1'b0;
                end else if (!req_next[i]) begin
                    if ($urandom_range(3) == 0) begin
                        req_next[i] = 1'b1;
                        cyc_next[i] = ($urandom_range(9) == 0) ? WIDTH'($urandom_range(30))
                                                               : WIDTH'($urandom_range(5));
                    end
                end else if ($urandom_range(49) == 0) begin
                    req_next[i] = 1'b0;
                end
            end
            tick();
        end

        req_next = '0;
        ticks(6);
        final_check = 1'b1;
        for (int w = 0; w < 10 && !final_done; w++) @(posedge clk);
        #1;
        if (!final_done) begin
            n_vec++;
            n_err++;
            $display("FAIL drain_timeout cyc=%0d final check never ran", cyc);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
